// File: rtl/tetris_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : tetris_pkg
//  Brief    : Shared playfield geometry, scoring constants, saturation
//             limits and line-clear FSM state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package tetris_pkg;

    localparam int C_ROWS = 20;
    localparam int C_COLS = 10;

    localparam logic [9:0]  C_LINES_MAX  = 10'd999;
    localparam logic [19:0] C_POINTS_MAX = 20'd999999;

    // Line-clear FSM state encoding
    localparam int         C_ST_W     = 3;
    localparam logic [2:0] C_ST_IDLE  = 3'd0;
    localparam logic [2:0] C_ST_READ  = 3'd1;
    localparam logic [2:0] C_ST_EVAL  = 3'd2;
    localparam logic [2:0] C_ST_FILL  = 3'd3;
    localparam logic [2:0] C_ST_SCORE = 3'd4;
    localparam logic [2:0] C_ST_DONE  = 3'd5;

    // Base score for k cleared rows; k is never above 4
    function automatic logic [10:0] base_score(input logic [2:0] k);
        case (k)
            3'd0:    return 11'd0;
            3'd1:    return 11'd40;
            3'd2:    return 11'd100;
            3'd3:    return 11'd300;
            default: return 11'd1200;
        endcase
    endfunction

    // Level for a given line total, capped at 9
    function automatic logic [3:0] level_of(input logic [9:0] lines);
        if (lines >= 10'd90)
            return 4'd9;
        else
            return 4'(lines / 10'd10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/score_calc.sv
`default_nettype none
// ============================================================================
//  Module   : score_calc
//  Brief    : Points for one clear sequence: base(k) * (level + 1) added to
//             the running score with saturation at the score ceiling.
//  Revision : 1.0  initial release
// ============================================================================
module score_calc
    import tetris_pkg::*;
(
    input  logic [2:0]  i_k,
    input  logic [3:0]  i_level,
    input  logic [19:0] i_points,
    output logic [19:0] o_points
);

    logic [10:0] w_base;
    logic [4:0]  w_mult;
    logic [14:0] w_gain;
    logic [20:0] w_sum;

    // Gain is at most 1200*10, so 15 bits hold it; the sum keeps a carry bit
    always_comb begin
        w_base   = base_score(i_k);
        w_mult   = {1'b0, i_level} + 5'd1;
        w_gain   = {4'd0, w_base} * {10'd0, w_mult};
        w_sum    = {1'b0, i_points} + {6'd0, w_gain};
        o_points = (w_sum > {1'b0, C_POINTS_MAX}) ? C_POINTS_MAX : w_sum[19:0];
    end

endmodule
`default_nettype wire

// File: rtl/line_clear_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : line_clear_ctl
//  Brief    : Scans the board bottom-up after a piece locks, compacts
//             non-full rows downward over cleared ones, zero-fills the top,
//             and updates lines, level, score and the game-over flag.
//  Revision : 1.0  initial release
// ============================================================================
module line_clear_ctl
    import tetris_pkg::*;
#(
    parameter int ROWS = C_ROWS,
    parameter int COLS = C_COLS
) (
    input  logic            pclk,
    input  logic            rst,
    input  logic            start,
    input  logic            new_game,
    output logic [4:0]      rd_addr,
    input  logic [COLS-1:0] rd_data,
    output logic            wr_en,
    output logic [4:0]      wr_addr,
    output logic [COLS-1:0] wr_data,
    output logic            busy,
    output logic            done,
    output logic [2:0]      last_clear,
    output logic [9:0]      lines,
    output logic [3:0]      level,
    output logic [19:0]     points,
    output logic            game_over
);

    logic [C_ST_W-1:0] r_state;
    logic [C_ST_W-1:0] w_state_nxt;
    logic [4:0]        r_row;        // scan row in READ/EVAL, fill row in FILL
    logic [2:0]        r_k;
    logic [2:0]        r_last_clear;
    logic [9:0]        r_lines;
    logic [3:0]        r_level;
    logic [19:0]       r_points;
    logic              r_game_over;

    logic              w_full;
    logic              w_start_ok;
    logic              w_fill_last;
    logic [2:0]        w_k_inc;
    logic [10:0]       w_lines_sum;
    logic [9:0]        w_lines_new;
    logic [19:0]       w_points_new;

    assign w_full      = &rd_data;
    assign w_start_ok  = start && !new_game && !r_game_over;
    assign w_fill_last = (r_row == ({2'b00, r_k} - 5'd1));
    assign w_k_inc     = (r_k >= 3'd4) ? 3'd4 : r_k + 3'd1;
    assign w_lines_sum = {1'b0, r_lines} + {8'd0, r_k};
    assign w_lines_new = (w_lines_sum > {1'b0, C_LINES_MAX}) ? C_LINES_MAX
                                                             : w_lines_sum[9:0];

    score_calc u_score_calc (
        .i_k      (r_k),
        .i_level  (r_level),
        .i_points (r_points),
        .o_points (w_points_new)
    );

    // State register; reset drops straight to IDLE
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) r_state <= C_ST_IDLE;
        else      r_state <= w_state_nxt;
    end

    // Next-state logic and board write port
    always_comb begin
        w_state_nxt = r_state;
        wr_en       = 1'b0;
        wr_addr     = 5'd0;
        wr_data     = '0;
        case (r_state)
            C_ST_IDLE:  if (w_start_ok) w_state_nxt = C_ST_READ;
            C_ST_READ:  w_state_nxt = C_ST_EVAL;
            C_ST_EVAL: begin
                // Rows below r+k were already read, so the shift never
                // overwrites an unscanned row
                if (!w_full && (r_k != 3'd0)) begin
                    wr_en   = 1'b1;
                    wr_addr = r_row + {2'b00, r_k};
                    wr_data = rd_data;
                end
                if (r_row != 5'd0)       w_state_nxt = C_ST_READ;
                else if (r_k != 3'd0)    w_state_nxt = C_ST_FILL;
                else                     w_state_nxt = C_ST_SCORE;
            end
            C_ST_FILL: begin
                wr_en   = 1'b1;
                wr_addr = r_row;
                if (w_fill_last) w_state_nxt = C_ST_SCORE;
            end
            C_ST_SCORE: w_state_nxt = C_ST_DONE;
            C_ST_DONE:  w_state_nxt = C_ST_IDLE;
            default:    w_state_nxt = C_ST_IDLE;
        endcase
    end

    // Scan counters, statistics and sticky game-over flag
    always_ff @(posedge pclk or negedge rst) begin
        if (!rst) begin
            r_row        <= 5'd0;
            r_k          <= 3'd0;
            r_last_clear <= 3'd0;
            r_lines      <= 10'd0;
            r_level      <= 4'd0;
            r_points     <= 20'd0;
            r_game_over  <= 1'b0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (new_game) begin
                        r_last_clear <= 3'd0;
                        r_lines      <= 10'd0;
                        r_level      <= 4'd0;
                        r_points     <= 20'd0;
                        r_game_over  <= 1'b0;
                    end else if (start && !r_game_over) begin
                        r_row <= 5'(ROWS - 1);
                        r_k   <= 3'd0;
                    end
                end
                C_ST_EVAL: begin
                    if (w_full)
                        r_k <= w_k_inc;
                    else if ((r_row == 5'd0) && (rd_data != '0) && (r_k == 3'd0))
                        r_game_over <= 1'b1;
                    // Row stays at 0 on the last scan so FILL starts at the top
                    if (r_row != 5'd0) r_row <= r_row - 5'd1;
                end
                C_ST_FILL:  r_row <= r_row + 5'd1;
                C_ST_SCORE: begin
                    r_last_clear <= r_k;
                    r_lines      <= w_lines_new;
                    r_level      <= level_of(w_lines_new);
                    r_points     <= w_points_new;
                end
                default: ;
            endcase
        end
    end

    assign rd_addr    = r_row;
    assign busy       = (r_state != C_ST_IDLE);
    assign done       = (r_state == C_ST_DONE);
    assign last_clear = r_last_clear;
    assign lines      = r_lines;
    assign level      = r_level;
    assign points     = r_points;
    assign game_over  = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_line_clear_ctl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_line_clear_ctl
//  Brief    : Directed self-checking bench for line_clear_ctl with a
//             synchronous-read board memory model and a score model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_line_clear_ctl;

    logic        pclk = 1'b0;
    logic        rst;
    logic        start;
    logic        new_game;
    logic [4:0]  rd_addr;
    logic [9:0]  rd_data;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [9:0]  wr_data;
    logic        busy;
    logic        done;
    logic [2:0]  last_clear;
    logic [9:0]  lines;
    logic [3:0]  level;
    logic [19:0] points;
    logic        game_over;

    // Bench-side board loader
    logic        ld_en;
    logic [4:0]  ld_addr;
    logic [9:0]  ld_data;
    logic [9:0]  mem [0:19];

    int n_cmp = 0;
    int n_err = 0;
    int m_points, m_lines, m_level;
    int cyc, nwr;

    line_clear_ctl #(.ROWS(20), .COLS(10)) dut (
        .pclk       (pclk),
        .rst        (rst),
        .start      (start),
        .new_game   (new_game),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .done       (done),
        .last_clear (last_clear),
        .lines      (lines),
        .level      (level),
        .points     (points),
        .game_over  (game_over)
    );

    always #5 pclk = ~pclk;

    // Board memory: one-cycle read latency, bench loads take priority
    always @(posedge pclk) begin
        if (ld_en)      mem[ld_addr] <= ld_data;
        else if (wr_en) mem[wr_addr] <= wr_data;
        rd_data <= mem[rd_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic set_row(input int a, input logic [9:0] d);
        ld_en = 1'b1; ld_addr = 5'(a); ld_data = d;
        tick();
        ld_en = 1'b0;
    endtask

    task automatic clear_board();
        for (int i = 0; i < 20; i++) set_row(i, 10'h000);
    endtask

    // Pulse start, count cycles to done (sampling edge = cycle 1) and writes
    task automatic run_seq(output int c, output int w);
        start = 1'b1;
        tick();
        start = 1'b0;
        c = 1; w = 0;
        while (!done && c < 200) begin
            if (wr_en) w++;
            tick();
            c++;
        end
        check_eq("seq_timeout", {31'd0, done}, 32'd1);
        tick();
    endtask

    task automatic model_score(input int k);
        int base;
        case (k)
            0: base = 0;
            1: base = 40;
            2: base = 100;
            3: base = 300;
            default: base = 1200;
        endcase
        m_points = m_points + base * (m_level + 1);
        if (m_points > 999999) m_points = 999999;
        m_lines = m_lines + k;
        if (m_lines > 999) m_lines = 999;
        m_level = (m_lines / 10 > 9) ? 9 : m_lines / 10;
    endtask

    task automatic check_score(input int k);
        model_score(k);
        check_eq("last_clear", 32'(last_clear), 32'(k));
        check_eq("points",     32'(points),     32'(m_points));
        check_eq("lines",      32'(lines),      32'(m_lines));
        check_eq("level",      32'(level),      32'(m_level));
    endtask

    task automatic tetris_board();
        for (int i = 16; i < 20; i++) set_row(i, 10'h3FF);
    endtask

    initial begin
        int any_busy;
        rst = 1'b0; start = 1'b0; new_game = 1'b0;
        ld_en = 1'b0; ld_addr = 5'd0; ld_data = 10'd0;
        m_points = 0; m_lines = 0; m_level = 0;
        repeat (3) tick();

        // Reset state
        check_eq("rst_busy",      32'(busy),       32'd0);
        check_eq("rst_wr_en",     32'(wr_en),      32'd0);
        check_eq("rst_rd_addr",   32'(rd_addr),    32'd0);
        check_eq("rst_done",      32'(done),       32'd0);
        check_eq("rst_game_over", 32'(game_over),  32'd0);
        check_eq("rst_points",    32'(points),     32'd0);
        check_eq("rst_lines",     32'(lines),      32'd0);
        rst = 1'b1;
        clear_board();

        // Empty board: no writes, nothing scored, 42-cycle latency
        run_seq(cyc, nwr);
        check_eq("t1_latency", 32'(cyc), 32'd42);
        check_eq("t1_writes",  32'(nwr), 32'd0);
        check_score(0);

        // Single clear at level 0
        set_row(19, 10'h3FF);
        set_row(18, 10'h001);
        run_seq(cyc, nwr);
        check_eq("t2_latency", 32'(cyc),     32'd43);
        check_eq("t2_writes",  32'(nwr),     32'd20);
        check_eq("t2_row19",   32'(mem[19]), 32'h001);
        check_eq("t2_row18",   32'(mem[18]), 32'h000);
        check_eq("t2_row0",    32'(mem[0]),  32'h000);
        check_eq("t2_points",  32'(points),  32'd40);
        check_score(1);

        // Climb to level 2 (lines 21, points 8440), then a tetris scores 3600
        clear_board();
        for (int t = 0; t < 5; t++) begin
            tetris_board();
            run_seq(cyc, nwr);
            check_score(4);
        end
        check_eq("t3_pre_level",  32'(level),  32'd2);
        check_eq("t3_pre_points", 32'(points), 32'd8440);
        tetris_board();
        set_row(15, 10'h155);
        set_row(0, 10'h0F0);
        run_seq(cyc, nwr);
        check_eq("t3_latency", 32'(cyc),     32'd46);
        check_eq("t3_writes",  32'(nwr),     32'd20);
        check_eq("t3_points",  32'(points),  32'd12040);
        check_eq("t3_row19",   32'(mem[19]), 32'h155);
        check_eq("t3_row4",    32'(mem[4]),  32'h0F0);
        for (int i = 0; i < 4; i++) check_eq("t3_top_zero", 32'(mem[i]), 32'd0);
        check_score(4);

        // Occupied top row with no clears ends the game
        clear_board();
        set_row(0, 10'h200);
        run_seq(cyc, nwr);
        check_eq("go_latency", 32'(cyc),       32'd42);
        check_eq("go_flag",    32'(game_over), 32'd1);
        check_score(0);
        start = 1'b1; tick(); start = 1'b0;
        any_busy = 0;
        for (int i = 0; i < 5; i++) begin
            if (busy) any_busy = 1;
            tick();
        end
        check_eq("go_start_ignored", 32'(any_busy), 32'd0);
        new_game = 1'b1; tick(); new_game = 1'b0;
        m_points = 0; m_lines = 0; m_level = 0;
        check_eq("ng_game_over", 32'(game_over),  32'd0);
        check_eq("ng_points",    32'(points),     32'd0);
        check_eq("ng_lines",     32'(lines),      32'd0);
        check_eq("ng_level",     32'(level),      32'd0);
        check_eq("ng_last",      32'(last_clear), 32'd0);

        // new_game and start together: no sequence
        clear_board();
        new_game = 1'b1; start = 1'b1; tick(); new_game = 1'b0; start = 1'b0;
        any_busy = 0;
        for (int i = 0; i < 4; i++) begin
            if (busy) any_busy = 1;
            tick();
        end
        check_eq("ng_start_busy", 32'(any_busy), 32'd0);

        // Asynchronous reset while evaluating row 10 with a write pending
        set_row(19, 10'h3FF);
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 19; i++) tick();
        check_eq("mr_rd_addr_pre", 32'(rd_addr), 32'd10);
        check_eq("mr_wr_en_pre",   32'(wr_en),   32'd1);
        rst = 1'b0;
        #1;
        check_eq("mr_busy",    32'(busy),    32'd0);
        check_eq("mr_wr_en",   32'(wr_en),   32'd0);
        check_eq("mr_rd_addr", 32'(rd_addr), 32'd0);
        tick(); tick();
        check_eq("mr_busy_hold", 32'(busy), 32'd0);
        rst = 1'b1;
        m_points = 0; m_lines = 0; m_level = 0;
        clear_board();

        // Saturation: 249 tetrises reach 996 lines, then two double clears
        for (int t = 0; t < 249; t++) begin
            tetris_board();
            run_seq(cyc, nwr);
            check_score(4);
        end
        check_eq("sat_lines_996", 32'(lines), 32'd996);
        for (int t = 0; t < 2; t++) begin
            set_row(18, 10'h3FF);
            set_row(19, 10'h3FF);
            run_seq(cyc, nwr);
            check_score(2);
        end
        check_eq("sat_lines",  32'(lines),  32'd999);
        check_eq("sat_points", 32'(points), 32'd999999);
        check_eq("sat_level",  32'(level),  32'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
